// File: rtl/call_stack.sv
// ---------------------------------------------------------------------------
// call_stack: parametrised return-address stack placed beside the PC logic.
// A call pushes its return address and a return pops it. The top entry is read
// combinationally from storage, so a return completes in one cycle.
//
// Parameters:
//   DATA_W : width of each stored entry (PC width)
//   DEPTH  : number of entries (must be >= 2)
//   CNT_W  : width of the occupancy count (derived from DEPTH, do not override)
//
// Ports:
//   clk     : clock; all state updates on the rising edge
//   reset   : asynchronous active-high reset (clears count and error flags)
//   push    : write din as the new top
//   pop     : remove the top entry
//   flush   : synchronous empty; push/pop are ignored in the same cycle
//   clr_err : synchronous clear of ovf/unf (an error in the same cycle wins)
//   din     : value to push
//   top     : current top entry, 0 when empty
//   count   : number of valid entries, 0..DEPTH
//   empty   : count == 0
//   full    : count == DEPTH
//   ovf     : sticky, a push was attempted while full
//   unf     : sticky, a pop or push+pop was attempted while empty
//
// push+pop on a non-empty stack replaces the top entry and leaves count as is.
//
// Build option CALL_STACK_WRAP_EN: storage becomes a circular buffer, and a
// push while full overwrites the oldest entry (ovf is still set to record
// the loss). Without it, a push while full is dropped.
// ---------------------------------------------------------------------------
module call_stack #(
   parameter int DATA_W = 10,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic              clr_err,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] top,
   output logic [CNT_W-1:0]  count,
   output logic              empty,
   output logic              full,
   output logic              ovf,
   output logic              unf
);

   localparam int               IDX_W   = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [CNT_W-1:0]  count_q, count_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic              wr_en;
   logic [IDX_W-1:0]  wr_addr;
   logic [IDX_W-1:0]  push_idx;   // slot the next push writes
   logic [IDX_W-1:0]  top_idx;    // slot holding the current top
   logic              is_empty, is_full;

   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == DEPTH_C);

`ifdef CALL_STACK_WRAP_EN
   logic [IDX_W-1:0] head_q, head_d;   // next write slot; the base sits count entries below it

   function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
      return (p == IDX_W'(DEPTH - 1)) ? '0 : p + IDX_W'(1);
   endfunction

   function automatic logic [IDX_W-1:0] ptr_dec(input logic [IDX_W-1:0] p);
      return (p == '0) ? IDX_W'(DEPTH - 1) : p - IDX_W'(1);
   endfunction

   assign push_idx = head_q;
   assign top_idx  = ptr_dec(head_q);
`else
   // Linear stack: the occupancy count doubles as the stack pointer. When
   // full, push_idx is never used, so truncating count_q is harmless.
   assign push_idx = IDX_W'(count_q);
   assign top_idx  = IDX_W'(count_q - CNT_W'(1));
`endif

   always_comb begin
      count_d = count_q;
      ovf_d   = ovf_q & ~clr_err;
      unf_d   = unf_q & ~clr_err;
      wr_en   = 1'b0;
      wr_addr = push_idx;
`ifdef CALL_STACK_WRAP_EN
      head_d  = head_q;
`endif
      if (flush) begin
         count_d = '0;
      end else if (push && pop) begin
         if (is_empty) begin
            unf_d = 1'b1;
         end else begin
            wr_en   = 1'b1;
            wr_addr = top_idx;
         end
      end else if (push) begin
         if (is_full) begin
            ovf_d = 1'b1;
`ifdef CALL_STACK_WRAP_EN
            // When full, head equals base, so this overwrites the oldest entry.
            wr_en  = 1'b1;
            head_d = ptr_inc(head_q);
`endif
         end else begin
            wr_en   = 1'b1;
            count_d = count_q + CNT_W'(1);
`ifdef CALL_STACK_WRAP_EN
            head_d  = ptr_inc(head_q);
`endif
         end
      end else if (pop) begin
         if (is_empty) begin
            unf_d = 1'b1;
         end else begin
            count_d = count_q - CNT_W'(1);
`ifdef CALL_STACK_WRAP_EN
            head_d  = ptr_dec(head_q);
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
`ifdef CALL_STACK_WRAP_EN
         head_q  <= '0;
`endif
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
`ifdef CALL_STACK_WRAP_EN
         head_q  <= head_d;
`endif
      end
   end

   // Storage is not reset; entries beyond count are never observed.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= din;
      end
   end

   assign top   = is_empty ? '0 : mem_q[top_idx];
   assign count = count_q;
   assign empty = is_empty;
   assign full  = is_full;
   assign ovf   = ovf_q;
   assign unf   = unf_q;

endmodule

// File: tb/tb_call_stack.sv
module tb_call_stack;

`ifdef CALL_STACK_WRAP_EN
   localparam int DEP = 4;
`else
   localparam int DEP = 8;
`endif
   localparam int DW = 10;
   localparam int CW = $clog2(DEP + 1);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          push = 1'b0, pop = 1'b0, flush = 1'b0, clr_err = 1'b0;
   logic [DW-1:0] din = '0;
   logic [DW-1:0] top;
   logic [CW-1:0] count;
   logic          empty, full, ovf, unf;

   int total = 0;
   int bad   = 0;

   call_stack #(.DATA_W(DW), .DEPTH(DEP)) dut (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .flush(flush),
      .clr_err(clr_err), .din(din), .top(top), .count(count),
      .empty(empty), .full(full), .ovf(ovf), .unf(unf)
   );

   always #5 clk = ~clk;

   // One clock cycle with the given controls; outputs are settled 1 ns after the edge.
   task automatic cyc(input logic pu, input logic po, input logic fl,
                      input logic ce, input logic [DW-1:0] d);
      push = pu; pop = po; flush = fl; clr_err = ce; din = d;
      @(posedge clk);
      #1;
      push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      cyc(0, 0, 0, 0, '0);
      total++; if (count !== CW'(0)) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
      total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL rst_flags got empty=%b full=%b exp empty=1 full=0", empty, full); end
      total++; if (top !== '0) begin bad++; $display("FAIL rst_top got=%h exp=000", top); end
      total++; if (ovf !== 1'b0 || unf !== 1'b0) begin bad++; $display("FAIL rst_err got ovf=%b unf=%b exp 0 0", ovf, unf); end
      cyc(1, 0, 0, 0, 10'h011);
      cyc(1, 0, 0, 0, 10'h022);
      cyc(1, 0, 0, 0, 10'h033);
      total++; if (count !== CW'(3) || top !== 10'h033) begin bad++; $display("FAIL pre_rst got count=%0d top=%h exp 3 033", count, top); end
      // Asynchronous reset: checked before any clock edge occurs.
      reset = 1'b1;
      #1;
      total++; if (count !== CW'(0) || empty !== 1'b1 || top !== '0) begin bad++; $display("FAIL async_rst got count=%0d empty=%b top=%h exp 0 1 000", count, empty, top); end
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic fill_full();
      for (int i = 1; i <= DEP; i++) cyc(1, 0, 0, 0, DW'(i * 16));
   endtask

   task automatic test_fill();
      do_reset();
      for (int i = 1; i <= DEP; i++) begin
         cyc(1, 0, 0, 0, DW'(i * 16));
         total++; if (top !== DW'(i * 16) || count !== CW'(i)) begin bad++; $display("FAIL push_%0d got top=%h count=%0d exp top=%h count=%0d", i, top, count, DW'(i * 16), i); end
      end
      total++; if (full !== 1'b1 || empty !== 1'b0) begin bad++; $display("FAIL full_flag got full=%b empty=%b exp 1 0", full, empty); end
      total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_before got=%b exp=0", ovf); end
      cyc(1, 0, 0, 0, 10'h3FF);
      total++; if (top !== 10'h080 || count !== CW'(8) || ovf !== 1'b1) begin bad++; $display("FAIL push_on_full got top=%h count=%0d ovf=%b exp 080 8 1", top, count, ovf); end
   endtask

   task automatic test_drain();
      for (int i = DEP - 1; i >= 0; i--) begin
         cyc(0, 1, 0, 0, '0);
         total++; if (top !== DW'(i * 16) || count !== CW'(i)) begin bad++; $display("FAIL pop_to_%0d got top=%h count=%0d exp top=%h count=%0d", i, top, count, DW'(i * 16), i); end
      end
      total++; if (empty !== 1'b1 || full !== 1'b0 || unf !== 1'b0) begin bad++; $display("FAIL drained got empty=%b full=%b unf=%b exp 1 0 0", empty, full, unf); end
      cyc(0, 1, 0, 0, '0);
      total++; if (unf !== 1'b1 || count !== CW'(0)) begin bad++; $display("FAIL pop_on_empty got unf=%b count=%0d exp 1 0", unf, count); end
   endtask

   task automatic test_replace();
      do_reset();
      cyc(1, 0, 0, 0, 10'h100);
      cyc(1, 1, 0, 0, 10'h155);
      total++; if (count !== CW'(1) || top !== 10'h155) begin bad++; $display("FAIL replace got count=%0d top=%h exp 1 155", count, top); end
      cyc(1, 0, 0, 0, 10'h200);
      cyc(0, 1, 0, 0, '0);
      total++; if (top !== 10'h155) begin bad++; $display("FAIL replace_below got top=%h exp 155", top); end
      cyc(0, 1, 0, 0, '0);
      cyc(1, 1, 0, 0, 10'h2AA);
      total++; if (unf !== 1'b1 || count !== CW'(0) || top !== '0) begin bad++; $display("FAIL replace_empty got unf=%b count=%0d top=%h exp 1 0 000", unf, count, top); end
      do_reset();
      fill_full();
      cyc(1, 1, 0, 0, 10'h3C3);
      total++; if (count !== CW'(8) || top !== 10'h3C3 || ovf !== 1'b0) begin bad++; $display("FAIL replace_full got count=%0d top=%h ovf=%b exp 8 3c3 0", count, top, ovf); end
      cyc(0, 1, 0, 0, '0);
      total++; if (top !== 10'h070) begin bad++; $display("FAIL replace_full_pop got top=%h exp 070", top); end
   endtask

   task automatic test_errors();
      do_reset();
      fill_full();
      cyc(1, 0, 0, 0, 10'h001);
      cyc(0, 0, 1, 0, '0);
      cyc(0, 1, 0, 0, '0);
      total++; if (ovf !== 1'b1 || unf !== 1'b1) begin bad++; $display("FAIL both_set got ovf=%b unf=%b exp 1 1", ovf, unf); end
      cyc(0, 0, 0, 1, '0);
      total++; if (ovf !== 1'b0 || unf !== 1'b0) begin bad++; $display("FAIL clr_err got ovf=%b unf=%b exp 0 0", ovf, unf); end
      fill_full();
      cyc(1, 0, 0, 0, 10'h001);
      cyc(0, 0, 1, 0, '0);
      total++; if (ovf !== 1'b1 || count !== CW'(0)) begin bad++; $display("FAIL flush_keeps_ovf got ovf=%b count=%0d exp 1 0", ovf, count); end
      cyc(0, 1, 0, 1, '0);
      total++; if (unf !== 1'b1 || ovf !== 1'b0) begin bad++; $display("FAIL set_beats_clr got unf=%b ovf=%b exp 1 0", unf, ovf); end
      for (int i = 1; i <= 5; i++) cyc(1, 0, 0, 0, DW'(i));
      total++; if (count !== CW'(5) || top !== 10'h005) begin bad++; $display("FAIL five got count=%0d top=%h exp 5 005", count, top); end
      cyc(1, 0, 1, 0, 10'h3FF);
      total++; if (count !== CW'(0) || empty !== 1'b1 || unf !== 1'b1 || ovf !== 1'b0) begin bad++; $display("FAIL flush got count=%0d empty=%b unf=%b ovf=%b exp 0 1 1 0", count, empty, unf, ovf); end
      cyc(0, 0, 0, 0, '0);
      total++; if (count !== CW'(0) || unf !== 1'b1) begin bad++; $display("FAIL idle_hold got count=%0d unf=%b exp 0 1", count, unf); end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 1; i <= 5; i++) cyc(1, 0, 0, 0, DW'(i));
      total++; if (count !== CW'(4) || top !== 10'h005 || ovf !== 1'b1 || full !== 1'b1) begin bad++; $display("FAIL wrap_push got count=%0d top=%h ovf=%b full=%b exp 4 005 1 1", count, top, ovf, full); end
      for (int i = 5; i >= 2; i--) begin
         total++; if (top !== DW'(i)) begin bad++; $display("FAIL wrap_pop_%0d got top=%h exp %h", i, top, DW'(i)); end
         cyc(0, 1, 0, 0, '0);
      end
      total++; if (empty !== 1'b1 || count !== CW'(0) || top !== '0) begin bad++; $display("FAIL wrap_empty got empty=%b count=%0d top=%h exp 1 0 000", empty, count, top); end
   endtask

   initial begin
      test_reset();
`ifdef CALL_STACK_WRAP_EN
      test_wrap();
`else
      test_fill();
      test_drain();
      test_replace();
      test_errors();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
